ex_mem_req_unit: RTL and testbench
==================================

// Module: ex_mem_req_unit
// PURPOSE
//  Parametrised data-memory request engine between the EX and MEM stages. Accepts one
//  load/store per handshake from EX and detects misalignment (ALE). Formats size/wstrb/wdata,
//  drives the SRAM-like data port and tracks up to DEPTH outstanding requests in order.
//  Returns aligned, extended load data to MEM and silently drops responses of requests
//  cancelled by a pipeline flush (exception/ertn).
// PARAMETERS
//  DEPTH   2   max outstanding (addr_ok seen, data_ok pending) requests; power of 2, >=2
//  ADDR_W  32  address width
//  TAG_W   5   opaque tag carried request->response (e.g. rf_waddr)
// PORTS
//  clk            in   1       clock
//  resetn         in   1       asynchronous, active-low reset
//  req_valid      in   1       EX offers a memory op
//  req_ready      out  1       op accepted this cycle
//  req_wr         in   1       1=store, 0=load
//  req_size       in   2       0=byte 1=half 2=word (`MEM_SIZE_*)
//  req_unsigned   in   1       zero-extend load (ld.bu/ld.hu)
//  req_addr       in   ADDR_W  byte address
//  req_wdata      in   32      store source (rkd_value)
//  req_tag        in   TAG_W   passthrough tag
//  flush          in   1       cancel everything in flight
//  ale            out  1       misaligned op consumed this cycle, not issued
//  data_sram_req  out  1       \
//  data_sram_wr   out  1        |
//  data_sram_size out  2        | SRAM-like master port
//  data_sram_addr out  ADDR_W   |
//  data_sram_wstrb out 4        |
//  data_sram_wdata out 32      /
//  data_sram_addr_ok in 1 ; data_sram_data_ok in 1 ; data_sram_rdata in 32
//  resp_valid     out  1       response for oldest live request (no backpressure)
//  resp_wr        out  1       response belongs to a store
//  resp_rdata     out  32      extended load data; 0 for stores
//  resp_tag       out  TAG_W   tag of that request
// BEHAVIOUR
//  Reset: all outputs 0; issue reg empty; FIFO empty; occupancy 0.
//  ALE = req_valid & ((size==1 & addr[0]) | (size==2 & addr[1:0]!=0)); ALE op takes req_ready=1,
//    ale=1 same cycle (comb), nothing issued/enqueued.
//  Issue reg (IDLE/PEND): aligned op accepted when req_ready -> PEND next cycle.
//    req_ready = ~flush & (IDLE | (data_sram_req & addr_ok)).
//  data_sram_req = PEND & (occ<DEPTH | data_ok). Fields stable while PEND.
//    size=req_size; wdata: byte x4, half x2, word as-is.
//    wstrb: byte 4'b0001<<a[1:0], half 4'b0011<<a[1:0], word 4'b1111; wstrb=0 for loads.
//  req & addr_ok: enqueue {wr,size,unsigned,a[1:0],tag,cancel=0}. Reg -> IDLE, or refilled same cycle.
//  data_ok: pop head. If cancel=0, resp_valid=1 same cycle (comb), using head metadata and rdata:
//    byte: rdata>>(8*off), low 8b sign/zero-ext; half: >>(16*off[1]), 16b ext; word: rdata.
//    If cancel=1, no resp_valid.
//  occ: +1 on enqueue, -1 on pop; simultaneous -> unchanged; never exceeds DEPTH.
//  data_ok with occ==0 is a protocol violation: ignored, occ stays 0.
//  flush (single cycle):
//    - PEND without addr_ok that cycle -> dropped (req withdrawn).
//    - PEND with addr_ok -> enqueued with cancel=1.
//    - all FIFO entries get cancel=1.
//    - data_ok in the flush cycle -> suppressed.
//    - req_valid ignored that cycle.
//  Ops accepted after flush are live.
//  Pointer wrap: modulo DEPTH; full/empty from occ, not pointer compare.
//  Reset mid-flight (resetn low) clears everything immediately; late data_ok after reset is
//    discarded by the occ==0 rule.
// STRUCTURE
//  macro.vh: `MEM_SIZE_B/H/W, metadata field widths, `MEM_META_LEN.
//  Sub-module mem_req_fifo: DEPTH-entry metadata FIFO with push/pop, occ, cancel_all.
//  Top: issue reg, ALE/wstrb/wdata formatting, load extension mux.
// TESTING
//  ld.w 0x100, addr_ok 1 cyc later, data_ok+rdata=0x8081_8283 2 cyc later
//    -> one resp, rdata=0x80818283, tag kept.
//  ld.b 0x103 rdata=0x8000_0000 -> 0xFFFFFF80; ld.bu -> 0x80; ld.hu 0x102 rdata=0xBEEF0000 -> 0xBEEF.
//  st.h 0x206 wdata=0x1234 -> size=1, wstrb=4'b1100, wdata=0x12341234; ld.h 0x201 -> ale=1, no req.
//  DEPTH=2, addr_ok every cyc, data_ok held off -> 2 issued, then req low until a data_ok;
//    pop+push same cycle keeps occ=2.
//  2 outstanding + PEND third, flush (no addr_ok) -> 3rd never issued; next 2 data_ok -> no resp;
//    next ld resp ok.
//  resetn low with 1 outstanding, then release; stray data_ok -> no resp_valid, occ stays 0.

Source files
------------

// File: rtl/ex_mem_req_unit_pkg.sv
// Shared definitions for the EX->MEM data-memory request engine.
//  - MEM_SIZE_* access-size encodings used on req_size and data_sram_size
//  - issue_state_e : state of the single-entry issue register
//  - mem_meta_t    : per-request metadata kept until the response returns
//  - helpers for misalignment detection, store formatting and load extension
package ex_mem_req_unit_pkg;

   localparam logic [1:0] MEM_SIZE_B = 2'd0;
   localparam logic [1:0] MEM_SIZE_H = 2'd1;
   localparam logic [1:0] MEM_SIZE_W = 2'd2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } issue_state_e;

   typedef struct packed {
      logic       wr;
      logic [1:0] size;
      logic       uns;
      logic [1:0] off;
   } mem_meta_t;

   localparam int MEM_META_LEN = $bits(mem_meta_t);

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == MEM_SIZE_H) && off[0]) || ((size == MEM_SIZE_W) && (off != 2'b00));
   endfunction

   // Byte lanes written by a store; loads never assert any strobe.
   function automatic logic [3:0] fmt_wstrb(input logic wr, input logic [1:0] size,
                                            input logic [1:0] off);
      logic [3:0] strb;
      case (size)
         MEM_SIZE_B: strb = 4'b0001 << off;
         MEM_SIZE_H: strb = 4'b0011 << off;
         default:    strb = 4'b1111;
      endcase
      return wr ? strb : 4'b0000;
   endfunction

   // Replicate the store source across all lanes so wstrb alone picks the bytes.
   function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] res;
      case (size)
         MEM_SIZE_B: res = {4{wdata[7:0]}};
         MEM_SIZE_H: res = {2{wdata[15:0]}};
         default:    res = wdata;
      endcase
      return res;
   endfunction

   // Select the addressed byte/half from the returned word and sign/zero extend it.
   function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = 8'(rdata >> {off, 3'b000});
      h = 16'(rdata >> {off[1], 4'b0000});
      case (size)
         MEM_SIZE_B: res = {{24{b[7] & ~uns}}, b};
         MEM_SIZE_H: res = {{16{h[15] & ~uns}}, h};
         default:    res = rdata;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ex_mem_req_unit_fifo.sv
// In-order metadata FIFO for requests that have been address-accepted but not yet answered.
// Ports:
//  clk, resetn          clock, asynchronous active-low reset
//  i_push/i_push_*      write one entry (metadata, tag, initial cancel flag)
//  i_pop                retire the head entry (ignored when empty)
//  i_cancel_all         mark every stored entry as cancelled
//  o_head_*             head entry contents (meaningful only when not empty)
//  o_occ/o_full/o_empty occupancy; full/empty derive from the count, not pointer compare
module ex_mem_req_unit_fifo
   import ex_mem_req_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int TAG_W = 5
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       i_push,
   input  mem_meta_t                  i_push_meta,
   input  logic [TAG_W-1:0]           i_push_tag,
   input  logic                       i_push_cancel,
   input  logic                       i_pop,
   input  logic                       i_cancel_all,
   output mem_meta_t                  o_head_meta,
   output logic [TAG_W-1:0]           o_head_tag,
   output logic                       o_head_cancel,
   output logic [$clog2(DEPTH+1)-1:0] o_occ,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);

   mem_meta_t        r_meta [DEPTH];
   logic [TAG_W-1:0] r_tag  [DEPTH];
   logic [DEPTH-1:0] r_cancel;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;

   logic w_pop;
   logic w_push;

   assign o_full  = (r_occ == OCC_W'(DEPTH));
   assign o_empty = (r_occ == '0);

   // A pop from empty is a protocol violation and is dropped; a push into a full
   // FIFO is only legal when the head retires in the same cycle.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   assign o_head_meta   = r_meta[r_rd_ptr];
   assign o_head_tag    = r_tag[r_rd_ptr];
   assign o_head_cancel = r_cancel[r_rd_ptr];
   assign o_occ         = r_occ;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_meta[i] <= '0;
            r_tag[i]  <= '0;
         end
         r_cancel <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (i_cancel_all)
            r_cancel <= '1;
         // Written after cancel_all so a same-cycle push keeps its own cancel flag.
         if (w_push) begin
            r_meta[r_wr_ptr]   <= i_push_meta;
            r_tag[r_wr_ptr]    <= i_push_tag;
            r_cancel[r_wr_ptr] <= i_push_cancel;
            r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule

// File: rtl/ex_mem_req_unit.sv
// Data-memory request engine between EX and MEM.
// Accepts one load/store per handshake, flags misaligned ops (ale) without issuing them,
// holds the aligned op in an issue register until the SRAM port takes it, tracks up to
// DEPTH outstanding requests in order and returns extended load data to MEM. Responses
// of requests cancelled by flush are dropped.
// Ports:
//  clk, resetn                      clock, asynchronous active-low reset
//  req_*                            EX request (valid/ready handshake)
//  flush                            cancel everything in flight this cycle
//  ale                              misaligned op consumed this cycle
//  data_sram_*                      SRAM-like master port (req/addr_ok, data_ok/rdata)
//  resp_*                           response for the oldest live request (no backpressure)
//  dbg_state, dbg_occ               issue register state and outstanding count
// Handshake: an EX op transfers on a cycle with req_valid & req_ready; an SRAM request
// transfers on a cycle with data_sram_req & data_sram_addr_ok; each data_sram_data_ok
// answers the oldest transferred request.
module ex_mem_req_unit
   import ex_mem_req_unit_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_wr,
   input  logic [1:0]                 req_size,
   input  logic                       req_unsigned,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [31:0]                req_wdata,
   input  logic [TAG_W-1:0]           req_tag,
   input  logic                       flush,
   output logic                       ale,
   output logic                       data_sram_req,
   output logic                       data_sram_wr,
   output logic [1:0]                 data_sram_size,
   output logic [ADDR_W-1:0]          data_sram_addr,
   output logic [3:0]                 data_sram_wstrb,
   output logic [31:0]                data_sram_wdata,
   input  logic                       data_sram_addr_ok,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   output logic                       resp_valid,
   output logic                       resp_wr,
   output logic [31:0]                resp_rdata,
   output logic [TAG_W-1:0]           resp_tag,
   output issue_state_e               dbg_state,
   output logic [$clog2(DEPTH+1)-1:0] dbg_occ
);

   issue_state_e      r_state;
   logic              r_wr;
   logic [1:0]        r_size;
   logic              r_uns;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_wstrb;
   logic [31:0]       r_wdata;
   logic [TAG_W-1:0]  r_tag;

   logic              w_mis;
   logic              w_accept;
   logic              w_issue;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   mem_meta_t         w_push_meta;
   mem_meta_t         w_head_meta;
   logic [TAG_W-1:0]  w_head_tag;
   logic              w_head_cancel;

   assign w_mis = is_misaligned(req_size, req_addr[1:0]);
   assign ale   = req_valid & ~flush & w_mis;

   // Issue only when a slot is free, or when the head retires in this same cycle.
   assign data_sram_req = (r_state == ST_PEND) & (~w_full | data_sram_data_ok);
   assign w_issue       = data_sram_req & data_sram_addr_ok;

   // Misaligned ops are always consumed (they never occupy the issue register).
   assign req_ready = ~flush & ((req_valid & w_mis) | (r_state == ST_IDLE) | w_issue);
   assign w_accept  = req_valid & req_ready & ~w_mis;

   assign data_sram_wr    = r_wr;
   assign data_sram_size  = r_size;
   assign data_sram_addr  = r_addr;
   assign data_sram_wstrb = r_wstrb;
   assign data_sram_wdata = r_wdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_wr    <= 1'b0;
         r_size  <= '0;
         r_uns   <= 1'b0;
         r_addr  <= '0;
         r_wstrb <= '0;
         r_wdata <= '0;
         r_tag   <= '0;
      end else if (flush) begin
         // A pending op without addr_ok is withdrawn; with addr_ok it is
         // enqueued as cancelled by the FIFO push below.
         r_state <= ST_IDLE;
      end else if (w_accept) begin
         r_state <= ST_PEND;
         r_wr    <= req_wr;
         r_size  <= req_size;
         r_uns   <= req_unsigned;
         r_addr  <= req_addr;
         r_wstrb <= fmt_wstrb(req_wr, req_size, req_addr[1:0]);
         r_wdata <= fmt_wdata(req_size, req_wdata);
         r_tag   <= req_tag;
      end else if (w_issue) begin
         r_state <= ST_IDLE;
      end
   end

   assign w_push_meta.wr   = r_wr;
   assign w_push_meta.size = r_size;
   assign w_push_meta.uns  = r_uns;
   assign w_push_meta.off  = r_addr[1:0];

   ex_mem_req_unit_fifo #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) u_fifo (
      .clk           (clk),
      .resetn        (resetn),
      .i_push        (w_issue),
      .i_push_meta   (w_push_meta),
      .i_push_tag    (r_tag),
      .i_push_cancel (flush),
      .i_pop         (w_pop),
      .i_cancel_all  (flush),
      .o_head_meta   (w_head_meta),
      .o_head_tag    (w_head_tag),
      .o_head_cancel (w_head_cancel),
      .o_occ         (dbg_occ),
      .o_full        (w_full),
      .o_empty       (w_empty)
   );

   // Stray data_ok with nothing outstanding (e.g. after reset) is ignored.
   assign w_pop      = data_sram_data_ok & ~w_empty;
   assign resp_valid = w_pop & ~w_head_cancel & ~flush;
   assign resp_wr    = resp_valid & w_head_meta.wr;
   assign resp_rdata = (resp_valid & ~w_head_meta.wr)
                     ? load_extend(w_head_meta.size, w_head_meta.uns, w_head_meta.off, data_sram_rdata)
                     : 32'h0;
   assign resp_tag   = resp_valid ? w_head_tag : '0;

   assign dbg_state  = r_state;

endmodule

// File: tb/tb_ex_mem_req_unit.sv
module tb_ex_mem_req_unit;
   import ex_mem_req_unit_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid, req_ready, req_wr, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_tag;
   logic        flush, ale;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        resp_valid, resp_wr;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_tag;
   issue_state_e dbg_state;
   logic [1:0]  dbg_occ;

   int checks = 0;
   int errors = 0;

   ex_mem_req_unit #(.DEPTH(DEPTH), .ADDR_W(32), .TAG_W(5)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
      .flush(flush), .ale(ale),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
      .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_rdata(resp_rdata), .resp_tag(resp_tag),
      .dbg_state(dbg_state), .dbg_occ(dbg_occ)
   );

   // clock
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      req_valid = 0; req_wr = 0; req_size = 0; req_unsigned = 0;
      req_addr = 0; req_wdata = 0; req_tag = 0; flush = 0;
      data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
   endtask

   task automatic drive_req(input logic wr, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] tag);
      req_valid = 1; req_wr = wr; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_tag = tag;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drive_idle();
      resetn = 0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (data_sram_req !== 1'b0) begin errors++; $display("FAIL reset_sram_req: got %b exp 0", data_sram_req); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b exp 0", resp_valid); end
      checks++; if (ale !== 1'b0) begin errors++; $display("FAIL reset_ale: got %b exp 0", ale); end
      checks++; if (dbg_occ !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d exp 0", dbg_occ); end
      checks++; if ({data_sram_addr, data_sram_wstrb, data_sram_wdata} !== '0) begin errors++; $display("FAIL reset_sram_fields: got %h exp 0", {data_sram_addr, data_sram_wstrb, data_sram_wdata}); end
      @(negedge clk);
      resetn = 1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready: got %b exp 1", req_ready); end
   endtask

   task automatic test_load_ext();
      logic [1:0]  t_size [6];
      logic        t_uns  [6];
      logic [31:0] t_addr [6];
      logic [31:0] t_rd   [6];
      logic [31:0] t_exp  [6];
      logic [4:0]  tag;
      t_size = '{MEM_SIZE_W, MEM_SIZE_B, MEM_SIZE_B, MEM_SIZE_H, MEM_SIZE_H, MEM_SIZE_B};
      t_uns  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      t_addr = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
      t_rd   = '{32'h8081_8283, 32'h8000_0000, 32'h8000_0000, 32'hBEEF_0000, 32'hBEEF_0000, 32'h0000_7F00};
      t_exp  = '{32'h8081_8283, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF, 32'hFFFF_BEEF, 32'h0000_007F};
      for (int i = 0; i < 6; i++) begin
         tag = 5'(i + 10);
         @(negedge clk); drive_req(0, t_size[i], t_uns[i], t_addr[i], 32'hFFFF_FFFF, tag); #1;
         checks++; if ({req_ready, ale} !== 2'b10) begin errors++; $display("FAIL ld_accept[%0d]: ready,ale got %b exp 10", i, {req_ready, ale}); end
         @(negedge clk); req_valid = 0; #1;
         checks++; if ({data_sram_req, req_ready} !== 2'b10) begin errors++; $display("FAIL ld_pend[%0d]: req,ready got %b exp 10", i, {data_sram_req, req_ready}); end
         checks++; if ({data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb} !== {1'b0, t_size[i], t_addr[i], 4'b0000}) begin errors++; $display("FAIL ld_fields[%0d]: got %h exp %h", i, {data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb}, {1'b0, t_size[i], t_addr[i], 4'b0000}); end
         @(negedge clk); data_sram_addr_ok = 1; #1;
         checks++; if (data_sram_req !== 1'b1) begin errors++; $display("FAIL ld_req_held[%0d]: got %b exp 1", i, data_sram_req); end
         @(negedge clk); data_sram_addr_ok = 0; #1;
         checks++; if ({data_sram_req, dbg_occ} !== {1'b0, 2'd1}) begin errors++; $display("FAIL ld_outstanding[%0d]: req,occ got %b exp 001", i, {data_sram_req, dbg_occ}); end
         @(negedge clk); data_sram_data_ok = 1; data_sram_rdata = t_rd[i]; #1;
         checks++; if ({resp_valid, resp_wr} !== 2'b10) begin errors++; $display("FAIL ld_resp_valid[%0d]: valid,wr got %b exp 10", i, {resp_valid, resp_wr}); end
         checks++; if (resp_rdata !== t_exp[i]) begin errors++; $display("FAIL ld_rdata[%0d]: got %h exp %h", i, resp_rdata, t_exp[i]); end
         checks++; if (resp_tag !== tag) begin errors++; $display("FAIL ld_tag[%0d]: got %h exp %h", i, resp_tag, tag); end
         @(negedge clk); data_sram_data_ok = 0; #1;
         checks++; if ({resp_valid, dbg_occ} !== 3'b000) begin errors++; $display("FAIL ld_drained[%0d]: valid,occ got %b exp 000", i, {resp_valid, dbg_occ}); end
      end
   endtask

   task automatic test_store_ale();
      logic [1:0]  t_size [3];
      logic [31:0] t_addr [3];
      logic [31:0] t_wd   [3];
      logic [3:0]  t_strb [3];
      logic [31:0] t_xwd  [3];
      logic [1:0]  a_size [3];
      logic [31:0] a_addr [3];
      t_size = '{MEM_SIZE_H, MEM_SIZE_B, MEM_SIZE_W};
      t_addr = '{32'h206, 32'h203, 32'h208};
      t_wd   = '{32'h0000_1234, 32'h1234_56A5, 32'hDEAD_BEEF};
      t_strb = '{4'b1100, 4'b1000, 4'b1111};
      t_xwd  = '{32'h1234_1234, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); drive_req(1, t_size[i], 0, t_addr[i], t_wd[i], 5'(i + 20)); #1;
         checks++; if ({req_ready, ale} !== 2'b10) begin errors++; $display("FAIL st_accept[%0d]: ready,ale got %b exp 10", i, {req_ready, ale}); end
         @(negedge clk); req_valid = 0; data_sram_addr_ok = 1; #1;
         checks++; if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_addr} !== {2'b11, t_size[i], t_addr[i]}) begin errors++; $display("FAIL st_req[%0d]: got %h exp %h", i, {data_sram_req, data_sram_wr, data_sram_size, data_sram_addr}, {2'b11, t_size[i], t_addr[i]}); end
         checks++; if (data_sram_wstrb !== t_strb[i]) begin errors++; $display("FAIL st_wstrb[%0d]: got %b exp %b", i, data_sram_wstrb, t_strb[i]); end
         checks++; if (data_sram_wdata !== t_xwd[i]) begin errors++; $display("FAIL st_wdata[%0d]: got %h exp %h", i, data_sram_wdata, t_xwd[i]); end
         @(negedge clk); data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h5555_5555; #1;
         checks++; if ({resp_valid, resp_wr, resp_rdata, resp_tag} !== {2'b11, 32'h0, 5'(i + 20)}) begin errors++; $display("FAIL st_resp[%0d]: got %h exp %h", i, {resp_valid, resp_wr, resp_rdata, resp_tag}, {2'b11, 32'h0, 5'(i + 20)}); end
         @(negedge clk); data_sram_data_ok = 0;
      end
      a_size = '{MEM_SIZE_H, MEM_SIZE_W, MEM_SIZE_W};
      a_addr = '{32'h201, 32'h102, 32'h203};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); drive_req(0, a_size[i], 0, a_addr[i], 0, 5'h1F); #1;
         checks++; if ({ale, req_ready} !== 2'b11) begin errors++; $display("FAIL ale_flag[%0d]: ale,ready got %b exp 11", i, {ale, req_ready}); end
         @(negedge clk); req_valid = 0; #1;
         checks++; if ({data_sram_req, ale, dbg_occ} !== 4'b0000) begin errors++; $display("FAIL ale_no_issue[%0d]: req,ale,occ got %b exp 0000", i, {data_sram_req, ale, dbg_occ}); end
      end
   endtask

   task automatic fill_two_plus_pend(input logic [4:0] t0);
      // three back-to-back loads with addr_ok held high: two go out, third waits
      @(negedge clk); drive_req(0, MEM_SIZE_W, 0, 32'h300, 0, t0); data_sram_addr_ok = 1;
      @(negedge clk); drive_req(0, MEM_SIZE_W, 0, 32'h304, 0, t0 + 5'd1);
      @(negedge clk); drive_req(0, MEM_SIZE_W, 0, 32'h308, 0, t0 + 5'd2);
   endtask

   task automatic test_depth_limit();
      fill_two_plus_pend(5'd1);
      @(negedge clk); req_valid = 0; #1;
      checks++; if ({data_sram_req, req_ready, dbg_occ} !== {2'b00, 2'd2}) begin errors++; $display("FAIL depth_stall: req,ready,occ got %b exp 0010", {data_sram_req, req_ready, dbg_occ}); end
      @(negedge clk); #1;
      checks++; if (data_sram_req !== 1'b0) begin errors++; $display("FAIL depth_stall2: got %b exp 0", data_sram_req); end
      @(negedge clk); data_sram_data_ok = 1; data_sram_rdata = 32'h1111_1111; #1;
      checks++; if ({data_sram_req, resp_valid, resp_tag} !== {2'b11, 5'd1}) begin errors++; $display("FAIL depth_pop_push: req,valid,tag got %h exp %h", {data_sram_req, resp_valid, resp_tag}, {2'b11, 5'd1}); end
      @(negedge clk); data_sram_data_ok = 0; data_sram_addr_ok = 0; #1;
      checks++; if ({dbg_occ, data_sram_req} !== {2'd2, 1'b0}) begin errors++; $display("FAIL depth_occ_kept: occ,req got %b exp 100", {dbg_occ, data_sram_req}); end
      @(negedge clk); data_sram_data_ok = 1; data_sram_rdata = 32'h2222_2222; #1;
      checks++; if ({resp_valid, resp_tag, resp_rdata} !== {1'b1, 5'd2, 32'h2222_2222}) begin errors++; $display("FAIL depth_resp2: got %h", {resp_valid, resp_tag, resp_rdata}); end
      @(negedge clk); data_sram_rdata = 32'h3333_3333; #1;
      checks++; if ({resp_valid, resp_tag, resp_rdata} !== {1'b1, 5'd3, 32'h3333_3333}) begin errors++; $display("FAIL depth_resp3: got %h", {resp_valid, resp_tag, resp_rdata}); end
      @(negedge clk); data_sram_data_ok = 0; #1;
      checks++; if (dbg_occ !== 2'd0) begin errors++; $display("FAIL depth_empty: got %0d exp 0", dbg_occ); end
   endtask

   task automatic test_flush();
      fill_two_plus_pend(5'd4);
      @(negedge clk); drive_req(0, MEM_SIZE_W, 0, 32'h30C, 0, 5'd7); data_sram_addr_ok = 0; flush = 1; #1;
      checks++; if ({req_ready, ale} !== 2'b00) begin errors++; $display("FAIL flush_ignores_req: ready,ale got %b exp 00", {req_ready, ale}); end
      @(negedge clk); req_valid = 0; flush = 0; data_sram_addr_ok = 1; #1;
      checks++; if ({data_sram_req, dbg_occ} !== {1'b0, 2'd2}) begin errors++; $display("FAIL flush_withdrawn: req,occ got %b exp 010", {data_sram_req, dbg_occ}); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = $urandom; #1;
         checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_cancelled_resp[%0d]: got %b exp 0", i, resp_valid); end
      end
      @(negedge clk); data_sram_data_ok = 0; drive_req(0, MEM_SIZE_W, 0, 32'h400, 0, 5'd8); #1;
      checks++; if ({dbg_occ, data_sram_req, req_ready} !== {2'd0, 2'b01}) begin errors++; $display("FAIL flush_drained: occ,req,ready got %b exp 0001", {dbg_occ, data_sram_req, req_ready}); end
      @(negedge clk); req_valid = 0; data_sram_addr_ok = 1;
      @(negedge clk); data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hCAFE_F00D; #1;
      checks++; if ({resp_valid, resp_tag, resp_rdata} !== {1'b1, 5'd8, 32'hCAFE_F00D}) begin errors++; $display("FAIL flush_after_live: got %h", {resp_valid, resp_tag, resp_rdata}); end
      // flush in the same cycle as addr_ok: request goes out but its response is dropped
      @(negedge clk); data_sram_data_ok = 0; drive_req(0, MEM_SIZE_W, 0, 32'h404, 0, 5'd9);
      @(negedge clk); req_valid = 0; data_sram_addr_ok = 1; flush = 1; #1;
      checks++; if (data_sram_req !== 1'b1) begin errors++; $display("FAIL flush_with_addr_ok_req: got %b exp 1", data_sram_req); end
      @(negedge clk); data_sram_addr_ok = 0; flush = 0; #1;
      checks++; if (dbg_occ !== 2'd1) begin errors++; $display("FAIL flush_enq_cancelled: occ got %0d exp 1", dbg_occ); end
      @(negedge clk); data_sram_data_ok = 1; #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_enq_resp: got %b exp 0", resp_valid); end
      // data_ok arriving in the flush cycle is suppressed even for a live request
      @(negedge clk); data_sram_data_ok = 0; drive_req(0, MEM_SIZE_W, 0, 32'h408, 0, 5'd10);
      @(negedge clk); req_valid = 0; data_sram_addr_ok = 1;
      @(negedge clk); data_sram_addr_ok = 0; data_sram_data_ok = 1; flush = 1; #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_same_cycle_data_ok: got %b exp 0", resp_valid); end
      @(negedge clk); data_sram_data_ok = 0; flush = 0; #1;
      checks++; if (dbg_occ !== 2'd0) begin errors++; $display("FAIL flush_same_cycle_occ: got %0d exp 0", dbg_occ); end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk); drive_req(0, MEM_SIZE_W, 0, 32'h500, 0, 5'd12);
      @(negedge clk); req_valid = 0; data_sram_addr_ok = 1;
      @(negedge clk); data_sram_addr_ok = 0; #1;
      checks++; if (dbg_occ !== 2'd1) begin errors++; $display("FAIL rst_mid_pre_occ: got %0d exp 1", dbg_occ); end
      @(negedge clk); resetn = 0; #1;
      checks++; if ({dbg_occ, data_sram_req, resp_valid} !== 4'b0000) begin errors++; $display("FAIL rst_mid_clear: occ,req,valid got %b exp 0000", {dbg_occ, data_sram_req, resp_valid}); end
      @(negedge clk); resetn = 1;
      @(negedge clk); data_sram_data_ok = 1; data_sram_rdata = 32'h7777_7777; #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stray_resp: got %b exp 0", resp_valid); end
      @(negedge clk); data_sram_data_ok = 0; #1;
      checks++; if (dbg_occ !== 2'd0) begin errors++; $display("FAIL rst_mid_stray_occ: got %0d exp 0", dbg_occ); end
   endtask

   // ---------------- randomized run against a reference model ----------------
   typedef struct {
      bit        wr;
      bit [1:0]  size;
      bit        uns;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit [4:0]  tag;
      bit        cancel;
   } op_t;

   task automatic test_random();
      op_t   exp_q[$];
      op_t   pend_op, cur, head;
      bit    pend = 0;
      bit    mis, e_ale, e_req, e_ready, e_resp;
      bit [31:0] e_strb, e_wdata, e_rdata, v;
      int    off;
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         cur.wr = 1'($urandom_range(0, 1));
         cur.size = 2'($urandom_range(0, 2));
         cur.uns = 1'($urandom_range(0, 1));
         cur.addr = $urandom & 32'h0000_0FFF;
         if ($urandom_range(0, 3) != 0) cur.addr = cur.addr & ~((32'd1 << cur.size) - 32'd1);
         cur.wdata = $urandom;
         cur.tag = 5'($urandom);
         cur.cancel = 0;
         drive_req(cur.wr, cur.size, cur.uns, cur.addr, cur.wdata, cur.tag);
         req_valid = ($urandom_range(0, 99) < 60);
         flush = ($urandom_range(0, 99) < 4);
         data_sram_addr_ok = ($urandom_range(0, 99) < 60);
         data_sram_data_ok = (exp_q.size() > 0) && ($urandom_range(0, 99) < 50);
         data_sram_rdata = $urandom;
         #1;
         mis = (cur.size == 1 && cur.addr[0]) || (cur.size == 2 && cur.addr[1:0] != 0);
         e_ale = req_valid && mis && !flush;
         e_req = pend && (exp_q.size() < DEPTH || data_sram_data_ok);
         e_ready = !flush && ((req_valid && mis) || !pend || (e_req && data_sram_addr_ok));
         checks++; if ({ale, req_ready, data_sram_req} !== {e_ale, e_ready, e_req}) begin errors++; $display("FAIL rnd_ctrl[%0d]: ale,ready,req got %b exp %b", n, {ale, req_ready, data_sram_req}, {e_ale, e_ready, e_req}); end
         checks++; if (dbg_occ !== 2'(exp_q.size())) begin errors++; $display("FAIL rnd_occ[%0d]: got %0d exp %0d", n, dbg_occ, exp_q.size()); end
         if (e_req) begin
            off = int'(pend_op.addr % 4);
            case (pend_op.size)
               0: begin e_strb = 32'd1 << off; e_wdata = (pend_op.wdata % 256) * 32'h0101_0101; end
               1: begin e_strb = 32'd3 << off; e_wdata = (pend_op.wdata % 65536) * 32'h0001_0001; end
               default: begin e_strb = 15; e_wdata = pend_op.wdata; end
            endcase
            if (!pend_op.wr) e_strb = 0;
            checks++; if ({data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata} !== {pend_op.wr, pend_op.size, pend_op.addr, e_strb[3:0], e_wdata}) begin errors++; $display("FAIL rnd_sram_fields[%0d]: got %h exp %h", n, {data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata}, {pend_op.wr, pend_op.size, pend_op.addr, e_strb[3:0], e_wdata}); end
         end
         e_resp = 0;
         if (data_sram_data_ok && exp_q.size() > 0) begin
            head = exp_q[0];
            e_resp = !head.cancel && !flush;
            off = int'(head.addr % 4);
            if (head.wr) e_rdata = 0;
            else if (head.size == 0) begin
               v = (data_sram_rdata >> (8 * off)) % 256;
               e_rdata = (!head.uns && v >= 128) ? v + 32'hFFFF_FF00 : v;
            end else if (head.size == 1) begin
               v = (data_sram_rdata >> (16 * (off / 2))) % 65536;
               e_rdata = (!head.uns && v >= 32768) ? v + 32'hFFFF_0000 : v;
            end else e_rdata = data_sram_rdata;
            if (e_resp) begin
               checks++; if ({resp_wr, resp_rdata, resp_tag} !== {head.wr, e_rdata, head.tag}) begin errors++; $display("FAIL rnd_resp_data[%0d]: got %h exp %h", n, {resp_wr, resp_rdata, resp_tag}, {head.wr, e_rdata, head.tag}); end
            end
         end
         checks++; if (resp_valid !== e_resp) begin errors++; $display("FAIL rnd_resp_valid[%0d]: got %b exp %b", n, resp_valid, e_resp); end
         // model update for the coming clock edge
         if (data_sram_data_ok && exp_q.size() > 0) void'(exp_q.pop_front());
         if (flush) foreach (exp_q[k]) exp_q[k].cancel = 1;
         if (e_req && data_sram_addr_ok) begin
            pend_op.cancel = flush;
            exp_q.push_back(pend_op);
         end
         if (flush) pend = 0;
         else if (req_valid && e_ready && !mis) begin pend = 1; pend_op = cur; end
         else if (e_req && data_sram_addr_ok) pend = 0;
      end
      @(negedge clk); drive_idle();
   endtask

   initial begin
      test_reset();
      test_load_ext();
      test_store_ale();
      test_depth_limit();
      test_flush();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
